// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (serial adder now,
// serial subtractor later).
//   state_t    : FSM states shared by the serial blocks
//   WIDTH_DEF  : default operand width
//   majority3  : carry function of a 1-bit full adder
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/full_adder_1b.sv
// Combinational 1-bit full adder.
//   a, b, cin : input bits
//   s         : sum bit
//   cout      : carry out
module full_adder_1b
  import arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = majority3(a, b, cin);

endmodule

// File: rtl/serial_add_4b.sv
// Bit-serial adder: out/Cout = x + y + Cin, one bit per clock, LSB first.
//   clk, rst : clock and synchronous active-high reset
//   start    : request an addition (sampled only when idle)
//   x, y     : addends, captured on the accepted start
//   Cin      : carry-in, captured on the accepted start
//   busy     : high while an operation is in flight (SHIFT or DONE)
//   done     : one-cycle pulse, coincident with the new out/Cout
//   out      : registered sum, held between operations
//   Cout     : registered carry-out of the MSB, held between operations
module serial_add_4b
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             Cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;

  logic             w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_s_next;

  full_adder_1b u_fa (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_c),
    .s    (w_sum),
    .cout (w_carry)
  );

  assign w_s_next = {w_sum, r_s_sr[WIDTH-1:1]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (r_cnt == LAST_CNT) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr <= x;
            r_b_sr <= y;
            r_c    <= Cin;
            r_s_sr <= '0;
            r_cnt  <= '0;
          end
        end
        SHIFT: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_c    <= w_carry;
          r_s_sr <= w_s_next;
          r_cnt  <= r_cnt + 1'b1;
          // Result is loaded on the last shift edge so it appears in the
          // same cycle as the done pulse (the DONE state).
          if (r_cnt == LAST_CNT) begin
            r_out  <= w_s_next;
            r_cout <= w_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign out  = r_out;
  assign Cout = r_cout;

endmodule
